// File: rtl/tag_array_param.sv
// Tag array: DEPTH x WIDTH storage with segmented write mask, one-cycle
// registered read (write-first on same-row collision) and a post-reset
// sweep that clears every row before user traffic is accepted.
//
// state | meaning
// ------+-------------------------------------------------------------
// INIT  | clear sweep running; one row zeroed per cycle, ports ignored
// READY | sweep done; reads and masked writes serviced
module tag_array_param #(
    parameter  int DEPTH  = 64,
    parameter  int WIDTH  = 184,
    parameter  int SEGS   = 8,
    localparam int SEG_W  = WIDTH / SEGS,
    localparam int ADDR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] R0_addr,
    input  logic              R0_en,
    output logic [WIDTH-1:0]  R0_data,
    input  logic [ADDR_W-1:0] W0_addr,
    input  logic              W0_en,
    input  logic [WIDTH-1:0]  W0_data,
    input  logic [SEGS-1:0]   W0_mask,
    output logic              init_busy
);

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    // One extra bit so DEPTH itself is representable for the range compare.
    localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   ptr, ptr_nxt;
    logic                sweep_we;
    logic                wr_in_range;
    logic                rd_in_range;
    logic                user_we;
    logic [ADDR_W-1:0]   rd_idx;
    logic [WIDTH-1:0]    rd_row;
    logic [WIDTH-1:0]    mem [DEPTH];

    assign wr_in_range = ({1'b0, W0_addr} < DEPTH_V);
    assign rd_in_range = ({1'b0, R0_addr} < DEPTH_V);
    assign user_we     = (state == READY) && W0_en && wr_in_range;
    // Out-of-range reads never touch the array; their result is forced to 0.
    assign rd_idx      = rd_in_range ? R0_addr : '0;

    // State and sweep pointer register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= INIT;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Next-state logic: advance the sweep pointer until the last row is cleared.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        sweep_we  = 1'b0;
        init_busy = 1'b0;
        case (state)
            INIT: begin
                init_busy = 1'b1;
                sweep_we  = 1'b1;
                if (ptr == LAST_PTR) begin
                    state_nxt = READY;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr + ADDR_W'(1);
                end
            end
            READY: begin
                state_nxt = READY;
            end
            default: begin
                state_nxt = INIT;
                ptr_nxt   = '0;
            end
        endcase
    end

    // Row write: sweep clear or masked user write; nothing is written during reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (sweep_we) begin
                mem[ptr] <= '0;
            end else if (user_we) begin
                for (int k = 0; k < SEGS; k++) begin
                    if (W0_mask[k]) begin
                        mem[W0_addr][k*SEG_W +: SEG_W] <= W0_data[k*SEG_W +: SEG_W];
                    end
                end
            end
        end
    end

    // Read row with same-row write segments forwarded (write-first).
    always_comb begin
        rd_row = mem[rd_idx];
        if (user_we && (W0_addr == R0_addr)) begin
            for (int k = 0; k < SEGS; k++) begin
                if (W0_mask[k]) begin
                    rd_row[k*SEG_W +: SEG_W] = W0_data[k*SEG_W +: SEG_W];
                end
            end
        end
    end

    // Registered read port; holds 0 while clearing, holds last value when idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            R0_data <= '0;
        end else if (state == INIT) begin
            R0_data <= '0;
        end else if (R0_en) begin
            R0_data <= rd_in_range ? rd_row : '0;
        end
    end

endmodule

// File: tb/tb_tag_array_param.sv
// Bench for tag_array_param: directed scenarios plus random traffic checked
// against a row-array model with write-first read semantics.
module tb_tag_array_param;

    localparam int W  = 184;
    localparam int SW = 23;

    logic          clock = 1'b0;
    logic          reset;
    logic [5:0]    R0_addr;
    logic          R0_en;
    logic [W-1:0]  R0_data;
    logic [5:0]    W0_addr;
    logic          W0_en;
    logic [W-1:0]  W0_data;
    logic [7:0]    W0_mask;
    logic          init_busy;

    logic          d48_reset;
    logic [5:0]    d48_raddr;
    logic          d48_ren;
    logic [W-1:0]  d48_rdata;
    logic [5:0]    d48_waddr;
    logic          d48_wen;
    logic [W-1:0]  d48_wdata;
    logic [7:0]    d48_wmask;
    logic          d48_busy;

    int            n_tests = 0;
    int            n_fail  = 0;

    logic [W-1:0]  model [64];
    logic [W-1:0]  exp_rd;
    logic [W-1:0]  ones;

    always #5 clock = ~clock;

    tag_array_param dut (
        .clock     (clock),
        .reset     (reset),
        .R0_addr   (R0_addr),
        .R0_en     (R0_en),
        .R0_data   (R0_data),
        .W0_addr   (W0_addr),
        .W0_en     (W0_en),
        .W0_data   (W0_data),
        .W0_mask   (W0_mask),
        .init_busy (init_busy)
    );

    tag_array_param #(.DEPTH(48)) dut48 (
        .clock     (clock),
        .reset     (d48_reset),
        .R0_addr   (d48_raddr),
        .R0_en     (d48_ren),
        .R0_data   (d48_rdata),
        .W0_addr   (d48_waddr),
        .W0_en     (d48_wen),
        .W0_data   (d48_wdata),
        .W0_mask   (d48_wmask),
        .init_busy (d48_busy)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_row();
        logic [191:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[W-1:0];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) model[i] = '0;
        exp_rd = '0;
    endtask

    // One clock of traffic on the main instance; model applies the write first,
    // then the read, which is exactly write-first behaviour.
    task automatic op(input logic we, input logic [5:0] wa, input logic [7:0] wm,
                      input logic [W-1:0] wd, input logic re, input logic [5:0] ra,
                      input string tag);
        W0_en = we; W0_addr = wa; W0_mask = wm; W0_data = wd;
        R0_en = re; R0_addr = ra;
        @(posedge clock);
        if (we)
            for (int k = 0; k < 8; k++)
                if (wm[k]) model[wa][k*SW +: SW] = wd[k*SW +: SW];
        if (re) exp_rd = model[ra];
        #1;
        check(tag, R0_data, exp_rd);
    endtask

    // Called just after reset drops: counts busy cycles while hammering the ports.
    task automatic sweep_check(input string tag);
        int cnt;
        cnt = 0;
        W0_en = 1'b1; W0_addr = 6'd0; W0_mask = 8'hFF; W0_data = ones;
        R0_en = 1'b1; R0_addr = 6'd0;
        for (int i = 0; i < 200 && init_busy; i++) begin
            cnt++;
            R0_addr = 6'($urandom_range(0, 63));
            @(posedge clock);
            #1;
            if (R0_data !== '0) check({tag, "_rdata_in_init"}, R0_data, '0);
        end
        W0_en = 1'b0; R0_en = 1'b0;
        check({tag, "_busy_cycles"}, cnt, 64);
        check({tag, "_busy_low"}, init_busy, 1'b0);
        check({tag, "_rdata_after_init"}, R0_data, '0);
        model_clear();
    endtask

    initial begin
        ones = '1;
        reset = 1'b1;
        R0_en = 0; R0_addr = 0; W0_en = 0; W0_addr = 0; W0_data = 0; W0_mask = 0;
        d48_reset = 1'b1;
        d48_ren = 0; d48_raddr = 0; d48_wen = 0; d48_waddr = 0; d48_wdata = 0; d48_wmask = 0;
        model_clear();

        // Reset for two cycles, then the clear sweep.
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", init_busy, 1'b1);
        check("rst_rdata", R0_data, '0);
        reset = 1'b0;
        sweep_check("sweep1");

        op(0, 0, 0, 0, 1, 6'd0,  "post_init_row0");
        op(0, 0, 0, 0, 1, 6'd31, "post_init_row31");
        op(0, 0, 0, 0, 1, 6'd63, "post_init_row63");

        // Partial-mask overwrite.
        op(1, 6'd5, 8'hFF, ones, 0, 0, "wr5_full");
        op(1, 6'd5, 8'h01, '0,   0, 0, "wr5_seg0");
        op(0, 0, 0, 0, 1, 6'd5, "rd5_model");
        check("rd5_const", R0_data, {{(W-23){1'b1}}, 23'd0});

        // Empty mask leaves the row alone.
        op(1, 6'd5, 8'h00, '0, 0, 0, "wr5_nomask");
        op(0, 0, 0, 0, 1, 6'd5, "rd5_nomask");

        // Same-cycle write and read of one row.
        op(1, 6'd9, 8'h80, ones, 1, 6'd9, "wf9_model");
        check("wf9_const", R0_data, {23'h7FFFFF, 161'd0});

        // Read holds while R0_en is low.
        op(1, 6'd3, 8'hFF, W'(12'hABC), 0, 0, "wr3");
        op(0, 0, 0, 0, 1, 6'd3, "rd3");
        for (int i = 0; i < 5; i++)
            op(1, 6'd3, 8'hFF, rand_row(), 0, 0, "hold3");
        check("hold3_const", R0_data, W'(12'hABC));

        // Random traffic with collisions encouraged via a narrow address window.
        for (int i = 0; i < 600; i++) begin
            logic [5:0] wa, ra;
            wa = (i < 300) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
            ra = ($urandom_range(0, 3) == 0) ? wa
                 : ((i < 300) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63)));
            op(1'($urandom), wa, 8'($urandom), rand_row(), 1'($urandom), ra, "rand");
        end
        for (int i = 0; i < 64; i++) op(0, 0, 0, 0, 1, 6'(i), "scan_pre_reset");

        // Reset in READY, then reset again at sweep pointer 20.
        reset = 1'b1;
        @(posedge clock); #1;
        check("rst_ready_rdata", R0_data, '0);
        check("rst_ready_busy", init_busy, 1'b1);
        reset = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        check("mid_sweep_busy", init_busy, 1'b1);
        reset = 1'b1;
        @(posedge clock); #1;
        check("mid_rst_busy", init_busy, 1'b1);
        reset = 1'b0;
        sweep_check("sweep2");
        for (int i = 0; i < 64; i++) op(0, 0, 0, 0, 1, 6'(i), "scan_after_sweep2");

        // DEPTH=48 instance: out-of-range accesses.
        d48_reset = 1'b0;
        begin
            int cnt;
            cnt = 0;
            for (int i = 0; i < 200 && d48_busy; i++) begin
                cnt++;
                @(posedge clock);
                #1;
            end
            check("d48_busy_cycles", cnt, 48);
        end
        d48_wen = 1; d48_waddr = 6'd47; d48_wmask = 8'hFF; d48_wdata = ones;
        @(posedge clock); #1;
        d48_wen = 1; d48_waddr = 6'd50; d48_wmask = 8'hFF; d48_wdata = ones;
        d48_ren = 1; d48_raddr = 6'd50;
        @(posedge clock); #1;
        d48_wen = 0;
        check("d48_oor_rd", d48_rdata, '0);
        d48_raddr = 6'd47;
        @(posedge clock); #1;
        check("d48_rd47", d48_rdata, ones);
        for (int i = 0; i < 47; i++) begin
            d48_raddr = 6'(i);
            @(posedge clock); #1;
            check("d48_scan", d48_rdata, '0);
        end
        d48_raddr = 6'd63;
        @(posedge clock); #1;
        check("d48_oor_rd63", d48_rdata, '0);
        d48_ren = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tag_array_param.md
TAG_ARRAY_PARAM -- requirements
Module: tag_array_param

Interface
REQ-001 Parameter DEPTH, default 64, number of rows (2..1024, need not be a power of two).
REQ-002 Parameter WIDTH, default 184, row width in bits.
REQ-003 Parameter SEGS, default 8, number of write-mask segments; WIDTH SHALL be divisible by SEGS; SEG_W = WIDTH/SEGS.
REQ-004 Derived ADDR_W = max(1, ceil(log2(DEPTH))).
REQ-005 The block SHALL use one clock and a synchronous, active-high reset, exactly as decided.
REQ-006 clock  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 R0_addr  input  ADDR_W  read row address.
REQ-009 R0_en  input  1  read request.
REQ-010 R0_data  output  WIDTH  registered read data.
REQ-011 W0_addr  input  ADDR_W  write row address.
REQ-012 W0_en  input  1  write request.
REQ-013 W0_data  input  WIDTH  write data.
REQ-014 W0_mask  input  SEGS  per-segment write enable; bit k covers bits [k*SEG_W +: SEG_W].
REQ-015 init_busy  output  1  high while the post-reset clear sweep runs.

Function
REQ-016 The FSM SHALL have two states, INIT and READY; reset forces INIT with sweep pointer 0.
REQ-017 In INIT, each cycle with reset low SHALL write all-zero to row[ptr] and increment ptr; when ptr = DEPTH-1 is written, the next state SHALL be READY.
REQ-018 init_busy SHALL be 1 in INIT and 0 in READY, i.e. high for exactly DEPTH cycles after reset deasserts.
REQ-019 In INIT, R0_en and W0_en SHALL be ignored and R0_data SHALL hold 0.
REQ-020 In READY, W0_en=1 SHALL update row[W0_addr] at the clock edge, segment k only where W0_mask[k]=1; other segments keep their value.
REQ-021 W0_en=1 with W0_mask all zero SHALL leave memory unchanged.
REQ-022 Read latency SHALL be one cycle: R0_en=1 at edge N gives row[R0_addr] on R0_data after edge N.
REQ-023 With R0_en=0, R0_data SHALL hold its previous value, never X.
REQ-024 Same-cycle read and write to the same address SHALL be write-first: R0_data = old row with masked segments replaced by W0_data.
REQ-025 Read and write to different addresses in the same cycle SHALL proceed independently.
REQ-026 Addresses >= DEPTH SHALL be out of range: writes ignored; reads return all-zero.
REQ-027 The memory array SHALL have exactly DEPTH rows of WIDTH bits, with no address truncation or aliasing.

Reset
REQ-028 While reset=1: state=INIT, ptr=0, R0_data=0, init_busy=1, and no write of user data occurs.
REQ-029 Reset asserted mid-sweep or in READY SHALL restart the sweep from row 0 on the first cycle with reset low.
REQ-030 Memory contents SHALL be undefined only before the first completed sweep; after it every row SHALL read 0.

Verification
REQ-031 Reset 2 cycles, release, count init_busy -> high exactly 64 cycles; then read rows 0, 31 and 63 -> all 0.
REQ-032 Write row 5 with mask 0xFF and data all-ones, then row 5 with mask 0x01 and data 0 -> row 5 reads with bits [22:0]=0 and all other bits 1.
REQ-033 Same cycle: write row 9 with mask 0x80 and data all-ones, and read row 9 -> next-cycle R0_data has bits [183:161]=1 and the rest 0.
REQ-034 Read row 3 = 0xABC, then hold R0_en=0 for 5 cycles while writing row 3 -> R0_data stays 0xABC.
REQ-035 Assert reset at sweep pointer 20 -> on release, init_busy is high for 64 cycles again and rows 0..63 read 0.
REQ-036 DEPTH=48: write address 50 and read address 50 -> no row changes, and R0_data = 0.
